// File: rtl/dff_pipe_chain.sv
// Purpose : WIDTH-bit, DEPTH-stage register pipeline with per-stage valid bits and bubble collapse.
// Latency : DEPTH cycles from accept to q when never stalled (1 cycle for DEPTH=1).
// Backpress: stalls ripple upstream stage by stage; in_ready drops only when every stage holds data and out_ready=0.
//
// Ports:
//   clk        clock, all state changes on posedge
//   rst        synchronous active-high reset (highest priority)
//   flush      synchronous clear of every stage valid bit, blocks both handshakes this cycle
//   in_valid   producer offers d
//   in_ready   pipeline takes d this cycle (combinational from out_ready)
//   d          input data
//   out_valid  q holds valid data (registered)
//   out_ready  consumer takes q this cycle
//   q          last stage data register
//   count      number of occupied stages (registered)
//   full       count == DEPTH
//   empty      count == 0
module dff_pipe_chain #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             d,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             q,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] move;
    logic             accept;
    logic [CW-1:0]    count_r;

    // move[i]: the item in stage i leaves it at the next edge. Computed from the
    // output end backwards so a free slot anywhere downstream pulls everything
    // behind it forward (bubble collapse). Flush freezes all movement so the data
    // registers keep their contents while the valid bits are cleared.
    always_comb begin
        move = '0;
        if (!flush) begin
            move[DEPTH-1] = valid[DEPTH-1] && out_ready;
            for (int i = DEPTH - 2; i >= 0; i--) begin
                move[i] = valid[i] && (!valid[i+1] || move[i+1]);
            end
        end
    end

    assign in_ready  = !flush && (!valid[0] || move[0]);
    assign accept    = in_valid && in_ready;
    assign out_valid = valid[DEPTH-1] && !flush;
    assign q         = data[DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data[i] <= RST_VAL;
            end
        end else if (flush) begin
            valid   <= '0;
            count_r <= '0;
        end else begin
            valid[0] <= accept || (valid[0] && !move[0]);
            if (accept) begin
                data[0] <= d;
            end
            for (int i = 1; i < DEPTH; i++) begin
                valid[i] <= move[i-1] || (valid[i] && !move[i]);
                // Data registers load only when an item arrives; a stage that
                // empties keeps its old value, so q holds while out_valid=0.
                if (move[i-1]) begin
                    data[i] <= data[i-1];
                end
            end
            count_r <= count_r + CW'(accept) - CW'(move[DEPTH-1]);
        end
    end

    assign count = count_r;
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);

endmodule

// File: tb/tb_dff_pipe_chain.sv
module tb_dff_pipe_chain;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=4 instance
    logic       rst, flush, in_valid, out_ready;
    logic [7:0] d;
    logic       in_ready, out_valid, full, empty;
    logic [7:0] q;
    logic [2:0] count;

    // DEPTH=1 instance
    logic       rst_1, flush_1, in_valid_1, out_ready_1;
    logic [7:0] d_1;
    logic       in_ready_1, out_valid_1, full_1, empty_1;
    logic [7:0] q_1;
    logic [0:0] count_1;

    dff_pipe_chain #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h3C)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .d(d), .out_valid(out_valid), .out_ready(out_ready), .q(q),
        .count(count), .full(full), .empty(empty)
    );

    dff_pipe_chain #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) u1 (
        .clk(clk), .rst(rst_1), .flush(flush_1), .in_valid(in_valid_1), .in_ready(in_ready_1),
        .d(d_1), .out_valid(out_valid_1), .out_ready(out_ready_1), .q(q_1),
        .count(count_1), .full(full_1), .empty(empty_1)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk4(input string tag, input logic e_ir, input logic e_ov,
                        input logic [7:0] e_q, input int e_cnt);
        chk({tag, ".in_ready"},  32'(in_ready),  32'(e_ir));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, ".q"},         32'(q),         32'(e_q));
        chk({tag, ".count"},     32'(count),     32'(e_cnt));
        chk({tag, ".full"},      32'(full),      32'(e_cnt == 4));
        chk({tag, ".empty"},     32'(empty),     32'(e_cnt == 0));
    endtask

    task automatic chk1(input string tag, input logic e_ir, input logic e_ov,
                        input logic [7:0] e_q, input int e_cnt);
        chk({tag, ".in_ready"},  32'(in_ready_1),  32'(e_ir));
        chk({tag, ".out_valid"}, 32'(out_valid_1), 32'(e_ov));
        chk({tag, ".q"},         32'(q_1),         32'(e_q));
        chk({tag, ".count"},     32'(count_1),     32'(e_cnt));
        chk({tag, ".full"},      32'(full_1),      32'(e_cnt == 1));
        chk({tag, ".empty"},     32'(empty_1),     32'(e_cnt == 0));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst, flush, iv;
        logic [7:0] d;
        logic       ordy, chk_en;
        logic       ir, ov;
        logic [7:0] q;
        int         cnt;
    } vec_t;

    vec_t tbl [21];

    // Item-centric reference model: ordered list of in-flight items with the
    // stage index each one occupies.
    int         mpos [4];
    logic [7:0] mdat [4];
    int         mn;
    logic [7:0] mlast;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //          rst flush iv d      ordy chk ir ov q      cnt
        tbl[0]  = '{1, 0, 1, 8'hFF, 1, 0, 1, 0, 8'h3C, 0};
        tbl[1]  = '{1, 0, 1, 8'hFF, 1, 1, 1, 0, 8'h3C, 0};
        tbl[2]  = '{0, 0, 1, 8'hA5, 1, 1, 1, 0, 8'h3C, 0};
        tbl[3]  = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h3C, 1};
        tbl[4]  = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h3C, 1};
        tbl[5]  = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h3C, 1};
        tbl[6]  = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA5, 1};
        tbl[7]  = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'hA5, 0};
        tbl[8]  = '{0, 0, 1, 8'h11, 0, 1, 1, 0, 8'hA5, 0};
        tbl[9]  = '{0, 0, 1, 8'h12, 0, 1, 1, 0, 8'hA5, 1};
        tbl[10] = '{0, 0, 1, 8'h13, 0, 1, 1, 0, 8'hA5, 2};
        tbl[11] = '{0, 0, 1, 8'h14, 0, 1, 1, 0, 8'hA5, 3};
        tbl[12] = '{0, 0, 1, 8'h15, 0, 1, 0, 1, 8'h11, 4};
        tbl[13] = '{0, 0, 1, 8'h15, 0, 1, 0, 1, 8'h11, 4};
        tbl[14] = '{0, 0, 1, 8'h15, 1, 1, 1, 1, 8'h11, 4};
        tbl[15] = '{0, 0, 1, 8'h16, 1, 1, 1, 1, 8'h12, 4};
        tbl[16] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h13, 4};
        tbl[17] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h14, 3};
        tbl[18] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h15, 2};
        tbl[19] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h16, 1};
        tbl[20] = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h16, 0};

        rst_1 = 1'b1; flush_1 = 1'b0; in_valid_1 = 1'b0; out_ready_1 = 1'b1; d_1 = 8'h00;

        // ---- table: reset, single-item latency, backpressure/full ----
        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst; flush = tbl[i].flush; in_valid = tbl[i].iv;
            d = tbl[i].d; out_ready = tbl[i].ordy;
            @(negedge clk);
            if (tbl[i].chk_en) chk4($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].ov, tbl[i].q, tbl[i].cnt);
            next_cycle();
        end

        // ---- streaming 01..10 with out_ready high ----
        for (int c = 0; c < 21; c++) begin
            in_valid = (c < 16); d = 8'(c + 1); out_ready = 1'b1;
            @(negedge clk);
            if (c < 16) chk($sformatf("stream%0d.in_ready", c), 32'(in_ready), 32'd1);
            chk($sformatf("stream%0d.out_valid", c), 32'(out_valid), 32'((c >= 4) && (c < 20)));
            if (c >= 4 && c < 20) chk($sformatf("stream%0d.q", c), 32'(q), 32'(c - 3));
            next_cycle();
        end

        // ---- bubble collapse ----
        out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            in_valid = (c == 0) || (c == 3);
            d = (c == 0) ? 8'hAA : 8'hBB;
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk4("bubble.settled", 1, 1, 8'hAA, 2);
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk); chk4("bubble.out0", 1, 1, 8'hAA, 2); next_cycle();
        @(negedge clk); chk4("bubble.out1", 1, 1, 8'hBB, 1); next_cycle();
        @(negedge clk); chk4("bubble.done", 1, 0, 8'hBB, 0); next_cycle();

        // ---- flush on a full pipeline ----
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; d = 8'(8'h21 + c);
            next_cycle();
        end
        flush = 1'b1; in_valid = 1'b1; d = 8'h99; out_ready = 1'b1;
        @(negedge clk);
        chk("flush.in_ready", 32'(in_ready), 32'd0);
        chk("flush.out_valid", 32'(out_valid), 32'd0);
        next_cycle();
        flush = 1'b0; in_valid = 1'b1; d = 8'h77;
        @(negedge clk);
        chk4("flush.after", 1, 0, 8'h21, 0);
        next_cycle();
        in_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("flush.new%0d.out_valid", c), 32'(out_valid), 32'(c == 4));
            if (c == 4) chk("flush.new.q", 32'(q), 32'h77);
            next_cycle();
        end

        // ---- rst together with flush ----
        out_ready = 1'b0; in_valid = 1'b1; d = 8'h55;
        next_cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 5; c++) next_cycle();
        @(negedge clk); chk4("pre_rst", 1, 1, 8'h55, 1);
        next_cycle();
        rst = 1'b1; flush = 1'b1;
        next_cycle();
        rst = 1'b0; flush = 1'b0;
        @(negedge clk); chk4("rst_flush", 1, 0, 8'h3C, 0);
        next_cycle();

        // ---- DEPTH=1 instance ----
        rst_1 = 1'b0; in_valid_1 = 1'b1; d_1 = 8'hA5; out_ready_1 = 1'b1;
        @(negedge clk); chk1("d1.c0", 1, 0, 8'h3C, 0); next_cycle();
        in_valid_1 = 1'b0;
        @(negedge clk); chk1("d1.c1", 1, 1, 8'hA5, 1); next_cycle();
        @(negedge clk); chk1("d1.c2", 1, 0, 8'hA5, 0); next_cycle();
        out_ready_1 = 1'b0; in_valid_1 = 1'b1; d_1 = 8'hB1;
        @(negedge clk); chk1("d1.c3", 1, 0, 8'hA5, 0); next_cycle();
        d_1 = 8'hB2;
        @(negedge clk); chk1("d1.c4", 0, 1, 8'hB1, 1); next_cycle();
        out_ready_1 = 1'b1;
        @(negedge clk); chk1("d1.c5", 1, 1, 8'hB1, 1); next_cycle();
        in_valid_1 = 1'b0;
        @(negedge clk); chk1("d1.c6", 1, 1, 8'hB2, 1); next_cycle();
        @(negedge clk); chk1("d1.c7", 1, 0, 8'hB2, 0); next_cycle();

        // ---- randomized run against the reference model ----
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        next_cycle();
        mn = 0; mlast = 8'h3C;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic e_ir, e_ov, pop, acc;
            rst       = ($urandom_range(99) == 0);
            flush     = ($urandom_range(39) == 0);
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            d         = 8'($urandom);

            e_ir = !flush && (mn < 4 || out_ready);
            e_ov = !flush && (mn > 0) && (mpos[0] == 3);
            @(negedge clk);
            chk4($sformatf("rand%0d", cyc), e_ir, e_ov, mlast, mn);

            if (rst) begin
                mn = 0; mlast = 8'h3C;
            end else if (flush) begin
                mn = 0;
            end else begin
                pop = e_ov && out_ready;
                acc = in_valid && e_ir;
                if (pop) begin
                    for (int k = 0; k < 3; k++) begin
                        mpos[k] = mpos[k+1]; mdat[k] = mdat[k+1];
                    end
                    mn--;
                end
                for (int k = 0; k < mn; k++) begin
                    int bound, np;
                    bound = (k == 0) ? 3 : mpos[k-1] - 1;
                    np = mpos[k] + 1;
                    if (np > bound) np = bound;
                    mpos[k] = np;
                    if (np == 3) mlast = mdat[k];
                end
                if (acc) begin
                    mpos[mn] = 0; mdat[mn] = d; mn++;
                end
            end
            next_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dff_pipe_chain.md
Name: dff_pipe_chain

Overview:
- Parametrised successor to the single-bit D flip-flop: a WIDTH-bit, DEPTH-stage register pipeline.
- Adds a valid/ready handshake on both sides, per-stage valid bits with bubble collapsing, a synchronous flush, and occupancy status.
- Used as a retiming/buffering stage between producer and consumer blocks on one clock domain.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RST_VAL, 0, value loaded into every data register on reset (WIDTH bits).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of all stage valid bits.
- in_valid  input  1  producer has data on d.
- in_ready  output  1  pipeline accepts d this cycle.
- d  input  WIDTH  input data.
- out_valid  output  1  q holds valid data.
- out_ready  input  1  consumer accepts q this cycle.
- q  output  WIDTH  output data (last stage register).
- count  output  $clog2(DEPTH+1)  number of valid stages (registered).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Interface decision: one clock, clk; reset is rst, synchronous and active-high. Priority is rst > flush > normal operation.
- Reset (rst=1 at posedge):
  - All valid bits clear and all data registers load RST_VAL; count clears.
  - Outputs in the following cycle: q=RST_VAL, out_valid=0, count=0, empty=1, full=0, in_ready=1.
  - in_valid is ignored while rst=1.
- Stages are 0..DEPTH-1, with stage 0 at the input side. q = data[DEPTH-1] and out_valid = valid[DEPTH-1] (registered, no combinational path from d).
- Move conditions:
  - move[DEPTH-1] = valid[DEPTH-1] && out_ready.
  - move[i] for i<DEPTH-1 = valid[i] && (!valid[i+1] || move[i+1]).
- in_ready = !valid[0] || move[0]. This is a combinational ripple from out_ready; that is intentional and allowed.
- Accept = in_valid && in_ready.
  - Stage 0 loads d and sets valid.
  - Stage i+1 loads data[i] when move[i].
  - A stage whose item moves out and receives nothing clears its valid bit.
- Data registers load only when receiving an item. Clearing a valid bit leaves its data unchanged, so q holds its last value when out_valid=0.
- Latency is DEPTH cycles: an item accepted in cycle n is at q with out_valid=1 in cycle n+DEPTH if it is never stalled. DEPTH=1 gives 1 cycle.
- Throughput is one item per cycle when out_ready is held high; in_ready then stays 1.
- Bubble collapse: while the output stalls, upstream items advance into empty stages, so up to DEPTH items are held.
- Full: in_ready=0 unless out_ready=1 in the same cycle. If it is, dequeue and enqueue happen together and count is unchanged.
- count_next = count + accept - move[DEPTH-1]. full and empty are decoded from the count register.
- Flush (flush=1 and rst=0):
  - in_ready and out_valid are forced to 0 that cycle, so no transfer occurs on either side.
  - At the posedge all valid bits clear and count becomes 0.
  - Data registers are unchanged.
- Reset or flush in the middle of a stall discards all in-flight items. There is no partial output.

Test Plan:
- Reset: DEPTH=4, RST_VAL=8'h3C, drive in_valid=1/d=8'hFF with rst=1 for 2 cycles -> q=8'h3C, out_valid=0, count=0, empty=1, in_ready=1 in the first cycle after rst deasserts.
- Latency: out_ready=1, one item 8'hA5 accepted in cycle 0 -> out_valid=1, q=8'hA5 exactly in cycle 4, out_valid=0 in cycle 5. Repeat with DEPTH=1 -> item appears in cycle 1.
- Streaming: out_ready=1, send 8'h01..8'h10 back-to-back -> outputs appear in order, one per cycle from cycle 4 to cycle 19; in_ready stays 1 throughout.
- Backpressure and full:
  - out_ready=0, offer 6 items 8'h11..8'h16 -> 4 accepted, full=1, count=4, in_ready=0.
  - Raise out_ready -> in_ready=1 in the same cycle, 8'h15 is accepted concurrently, and output order is 11, 12, 13, 14, 15, 16 with no loss or duplication.
- Bubble collapse: out_ready=0, send 8'hAA, idle 2 cycles, send 8'hBB -> after settling, valid[3]=1 (AA) and valid[2]=1 (BB), count=2. Then out_ready=1 -> AA then BB on consecutive cycles.
- Flush and priority:
  - With the pipeline full, flush=1 for 1 cycle -> in_ready=0 and out_valid=0 that cycle; next cycle count=0, empty=1, q unchanged.
  - A new item sent after the flush appears after DEPTH cycles.
  - rst=1 together with flush=1 -> reset result, with q=RST_VAL.
